// File: rtl/harv_mem_arbiter_pkg.sv
// harv_mem_arbiter_pkg: shared arbiter state/grant types and bus constants.
package harv_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {GNT_IMEM, GNT_DMEM} grant_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/harv_mem_arbiter_if.sv
// harv_mem_arbiter_if: core imem/dmem request ports plus the shared Wishbone master bus.
interface harv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_i;
  logic [ADDR_WIDTH-1:0] imem_addr_i;
  logic                  imem_ack_o;
  logic                  imem_err_o;
  logic [DATA_WIDTH-1:0] imem_rdata_o;
  logic                  dmem_req_i;
  logic                  dmem_we_i;
  logic [3:0]            dmem_sel_i;
  logic [ADDR_WIDTH-1:0] dmem_addr_i;
  logic [DATA_WIDTH-1:0] dmem_wdata_i;
  logic                  dmem_ack_o;
  logic                  dmem_err_o;
  logic [DATA_WIDTH-1:0] dmem_rdata_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [3:0]            wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  modport master (
    input  imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_sel_i, dmem_addr_i, dmem_wdata_i,
    input  wb_data_i, wb_ack_i, wb_err_i,
    output imem_ack_o, imem_err_o, imem_rdata_o, dmem_ack_o, dmem_err_o, dmem_rdata_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o
  );
  modport slave (
    output imem_req_i, imem_addr_i, dmem_req_i, dmem_we_i, dmem_sel_i, dmem_addr_i, dmem_wdata_i,
    output wb_data_i, wb_ack_i, wb_err_i,
    input  imem_ack_o, imem_err_o, imem_rdata_o, dmem_ack_o, dmem_err_o, dmem_rdata_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/harv_mem_arbiter.sv
// harv_mem_arbiter: round-robin share of one Wishbone classic port between harv fetch and data ports,
// one registered transaction at a time with a saturating bus timeout.
module harv_mem_arbiter
  import harv_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            sys_clk,
  input logic            rst_n,
  harv_mem_arbiter_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  arb_state_t    state;
  grant_t        grant, last_grant, pick;
  logic [CW-1:0] cnt;
  logic          tmo, done, gi;
  always_comb begin
    pick = (bus.imem_req_i && bus.dmem_req_i) ? (last_grant == GNT_IMEM ? GNT_DMEM : GNT_IMEM)
         : (bus.imem_req_i ? GNT_IMEM : GNT_DMEM);
    tmo  = (TIMEOUT_CYCLES != 0) && (32'(cnt) == TIMEOUT_CYCLES - 1);
    done = bus.wb_ack_i || bus.wb_err_i || tmo;
    gi   = grant == GNT_IMEM;
  end
  // ack dominates err; a timeout is reported as err with zero data
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      grant            <= GNT_IMEM;
      last_grant       <= GNT_DMEM;
      cnt              <= '0;
      bus.wb_cyc_o     <= 1'b0;
      bus.wb_stb_o     <= 1'b0;
      bus.wb_we_o      <= 1'b0;
      bus.wb_sel_o     <= 4'h0;
      bus.wb_addr_o    <= {ADDR_WIDTH{1'b0}};
      bus.wb_data_o    <= {DATA_WIDTH{1'b0}};
      bus.imem_ack_o   <= 1'b0;
      bus.imem_err_o   <= 1'b0;
      bus.imem_rdata_o <= {DATA_WIDTH{1'b0}};
      bus.dmem_ack_o   <= 1'b0;
      bus.dmem_err_o   <= 1'b0;
      bus.dmem_rdata_o <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: if (bus.imem_req_i || bus.dmem_req_i) begin
          state         <= BUSY;
          grant         <= pick;
          cnt           <= '0;
          bus.wb_cyc_o  <= 1'b1;
          bus.wb_stb_o  <= 1'b1;
          bus.wb_we_o   <= pick == GNT_DMEM && bus.dmem_we_i;
          bus.wb_sel_o  <= pick == GNT_DMEM ? bus.dmem_sel_i : WB_SEL_ALL;
          bus.wb_addr_o <= pick == GNT_DMEM ? bus.dmem_addr_i : bus.imem_addr_i;
          bus.wb_data_o <= pick == GNT_DMEM ? bus.dmem_wdata_i : {DATA_WIDTH{1'b0}};
        end
        BUSY: begin
          cnt <= &cnt ? cnt : cnt + 1'b1;
          if (done) begin
            state            <= RESP;
            bus.wb_cyc_o     <= 1'b0;
            bus.wb_stb_o     <= 1'b0;
            bus.wb_sel_o     <= 4'h0;
            bus.imem_ack_o   <= gi && bus.wb_ack_i;
            bus.imem_err_o   <= gi && !bus.wb_ack_i;
            bus.dmem_ack_o   <= !gi && bus.wb_ack_i;
            bus.dmem_err_o   <= !gi && !bus.wb_ack_i;
            bus.imem_rdata_o <= (gi && bus.wb_ack_i) ? bus.wb_data_i : {DATA_WIDTH{1'b0}};
            bus.dmem_rdata_o <= (!gi && bus.wb_ack_i) ? bus.wb_data_i : {DATA_WIDTH{1'b0}};
          end
        end
        RESP: begin
          state            <= IDLE;
          last_grant       <= grant;
          bus.imem_ack_o   <= 1'b0;
          bus.imem_err_o   <= 1'b0;
          bus.imem_rdata_o <= {DATA_WIDTH{1'b0}};
          bus.dmem_ack_o   <= 1'b0;
          bus.dmem_err_o   <= 1'b0;
          bus.dmem_rdata_o <= {DATA_WIDTH{1'b0}};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_harv_mem_arbiter.sv
// tb_harv_mem_arbiter: directed checks of fetch, write, contention, timeout, ack/err priority and async reset.
module tb_harv_mem_arbiter;
  logic sys_clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  harv_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  harv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus.master)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.imem_req_i = 0; bus.imem_addr_i = 0;
    bus.dmem_req_i = 0; bus.dmem_we_i = 0; bus.dmem_sel_i = 0; bus.dmem_addr_i = 0; bus.dmem_wdata_i = 0;
    bus.wb_data_i = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;
    tick; tick;
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_iack", bus.imem_ack_o, 0);
    chk("rst_dack", bus.dmem_ack_o, 0);
    rst_n = 1'b1;
    tick;
    // single fetch
    bus.imem_req_i = 1; bus.imem_addr_i = 32'h100;
    tick;
    chk("f_cyc", bus.wb_cyc_o, 1);
    chk("f_stb", bus.wb_stb_o, 1);
    chk("f_addr", bus.wb_addr_o, 32'h100);
    chk("f_we", bus.wb_we_o, 0);
    chk("f_sel", bus.wb_sel_o, 4'hF);
    bus.wb_ack_i = 1; bus.wb_data_i = 32'hDEADBEEF;
    tick;
    bus.wb_ack_i = 0; bus.wb_data_i = 0;
    chk("f_cyc_resp", bus.wb_cyc_o, 0);
    chk("f_iack", bus.imem_ack_o, 1);
    chk("f_rdata", bus.imem_rdata_o, 32'hDEADBEEF);
    chk("f_dack", bus.dmem_ack_o, 0);
    bus.imem_req_i = 0;
    tick;
    chk("f_iack_end", bus.imem_ack_o, 0);
    chk("f_rdata_end", bus.imem_rdata_o, 0);
    // data write, inputs changed mid-transaction must not leak onto the bus
    bus.dmem_req_i = 1; bus.dmem_we_i = 1; bus.dmem_sel_i = 4'b0011;
    bus.dmem_addr_i = 32'h2004; bus.dmem_wdata_i = 32'h1234;
    tick;
    chk("w_cyc", bus.wb_cyc_o, 1);
    chk("w_we", bus.wb_we_o, 1);
    chk("w_sel", bus.wb_sel_o, 4'b0011);
    chk("w_addr", bus.wb_addr_o, 32'h2004);
    chk("w_data", bus.wb_data_o, 32'h1234);
    bus.dmem_addr_i = 32'hFFFF; bus.dmem_wdata_i = 32'h5555; bus.dmem_sel_i = 4'hC;
    tick;
    chk("w_hold_addr", bus.wb_addr_o, 32'h2004);
    chk("w_hold_data", bus.wb_data_o, 32'h1234);
    chk("w_hold_sel", bus.wb_sel_o, 4'b0011);
    bus.wb_ack_i = 1;
    tick;
    bus.wb_ack_i = 0;
    chk("w_dack", bus.dmem_ack_o, 1);
    chk("w_derr", bus.dmem_err_o, 0);
    chk("w_iack", bus.imem_ack_o, 0);
    bus.dmem_req_i = 0; bus.dmem_we_i = 0;
    tick;
    chk("w_dack_end", bus.dmem_ack_o, 0);
    // timeout of 4 BUSY cycles with no slave response
    bus.dmem_req_i = 1; bus.dmem_addr_i = 32'h3000; bus.wb_data_i = 32'hAAAA5555;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk($sformatf("t_cyc%0d", i), bus.wb_cyc_o, 1);
      chk($sformatf("t_derr_pre%0d", i), bus.dmem_err_o, 0);
    end
    tick;
    chk("t_cyc_resp", bus.wb_cyc_o, 0);
    chk("t_derr", bus.dmem_err_o, 1);
    chk("t_dack", bus.dmem_ack_o, 0);
    chk("t_rdata", bus.dmem_rdata_o, 0);
    bus.dmem_req_i = 0; bus.wb_data_i = 0;
    tick;
    chk("t_derr_end", bus.dmem_err_o, 0);
    tick;
    chk("t_idle_cyc", bus.wb_cyc_o, 0);
    // ack and err together: ack wins
    bus.imem_req_i = 1;
    tick;
    bus.wb_ack_i = 1; bus.wb_err_i = 1; bus.wb_data_i = 32'h55;
    tick;
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_data_i = 0;
    chk("ae_iack", bus.imem_ack_o, 1);
    chk("ae_ierr", bus.imem_err_o, 0);
    chk("ae_rdata", bus.imem_rdata_o, 32'h55);
    bus.imem_req_i = 0;
    tick;
    // plain slave error
    bus.dmem_req_i = 1;
    tick;
    bus.wb_err_i = 1; bus.wb_data_i = 32'h77;
    tick;
    bus.wb_err_i = 0; bus.wb_data_i = 0;
    chk("e_derr", bus.dmem_err_o, 1);
    chk("e_dack", bus.dmem_ack_o, 0);
    chk("e_rdata", bus.dmem_rdata_o, 0);
    bus.dmem_req_i = 0;
    tick;
    // contention after reset: imem, dmem, imem, dmem
    rst_n = 0;
    tick;
    rst_n = 1;
    bus.imem_addr_i = 32'h100; bus.dmem_addr_i = 32'h200; bus.dmem_we_i = 0;
    bus.imem_req_i = 1; bus.dmem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("c_addr%0d", i), bus.wb_addr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
      bus.wb_ack_i = 1;
      tick;
      bus.wb_ack_i = 0;
      chk($sformatf("c_iack%0d", i), bus.imem_ack_o, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("c_dack%0d", i), bus.dmem_ack_o, (i % 2 == 0) ? 0 : 1);
      tick;
    end
    // leave last_grant at imem, then a tie goes to dmem and reset hits mid-BUSY
    bus.dmem_req_i = 0;
    tick;
    bus.wb_ack_i = 1;
    tick;
    bus.wb_ack_i = 0;
    tick;
    bus.dmem_req_i = 1;
    tick;
    chk("r_tie_dmem", bus.wb_addr_o, 32'h200);
    chk("r_cyc_busy", bus.wb_cyc_o, 1);
    #2 rst_n = 0;
    #1;
    chk("r_cyc", bus.wb_cyc_o, 0);
    chk("r_stb", bus.wb_stb_o, 0);
    chk("r_sel", bus.wb_sel_o, 0);
    chk("r_iack", bus.imem_ack_o, 0);
    chk("r_dack", bus.dmem_ack_o, 0);
    tick;
    rst_n = 1;
    tick;
    chk("r_first_imem", bus.wb_addr_o, 32'h100);
    chk("r_cyc_after", bus.wb_cyc_o, 1);
    bus.imem_req_i = 0; bus.dmem_req_i = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/harv_mem_arbiter.md
# harv_mem_arbiter

Shares one Wishbone classic master port between the harv core's instruction-fetch and data-memory request ports, so the core runs against a single memory when `ENABLE_SECOND_MEMORY` is not defined. It sits between the core and the Controller's `core_*` bus in `processorci_top`. The block does round-robin arbitration, registers one transaction at a time, returns a registered single-cycle response to the winning requester, and aborts stuck transactions with a bus timeout.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width. Must be 32.
- `TIMEOUT_CYCLES`, 255: maximum number of BUSY cycles to wait for `wb_ack_i`. 0 disables the timeout.
- `sys_clk`  in  1  Single clock for the block.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `imem_req_i`  in  1  Fetch request. Held high until `imem_ack_o` or `imem_err_o`.
- `imem_addr_i`  in  32  Fetch address.
- `imem_ack_o`  out  1  One-cycle fetch completion.
- `imem_err_o`  out  1  One-cycle fetch error or timeout.
- `imem_rdata_o`  out  32  Fetched word. Valid while `imem_ack_o` is high.
- `dmem_req_i`  in  1  Data request. Same hold rule as `imem_req_i`.
- `dmem_we_i`  in  1  1 = write.
- `dmem_sel_i`  in  4  Byte enables.
- `dmem_addr_i`  in  32  Data address.
- `dmem_wdata_i`  in  32  Write data.
- `dmem_ack_o`, `dmem_err_o`  out  1  Same semantics as the imem versions.
- `dmem_rdata_o`  out  32  Read data. Valid while `dmem_ack_o` is high.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls.
- `wb_sel_o`  out  4  Wishbone byte enables.
- `wb_addr_o`, `wb_data_o`  out  32  Wishbone address and write data.
- `wb_data_i`  in  32  Wishbone read data.
- `wb_ack_i`, `wb_err_i`  in  1  Wishbone slave responses.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- **IDLE**
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester that is not `last_grant`.
  - On grant, latch we/sel/addr/wdata into the output registers and move to BUSY.
  - A fetch always drives `we=0` and `sel=4'hF`.
- **BUSY**
  - `wb_cyc_o` and `wb_stb_o` are high. Outputs come straight from registers.
  - On `wb_ack_i`: capture `wb_data_i`, set the ack flag, go to RESP.
  - On `wb_err_i`: set the err flag, go to RESP.
  - If the timeout counter reaches `TIMEOUT_CYCLES` with no response: set the err flag, go to RESP.
  - If ack and err are high in the same cycle, ack wins.
- **RESP**
  - `cyc` and `stb` are low.
  - Exactly one of `<grant>_ack_o` or `<grant>_err_o` is high for this one cycle.
  - `rdata_o` carries the captured word on ack and 0 on err.
  - `last_grant` updates to the granted requester.
  - Requests are ignored in this state. Next state is always IDLE.
- The timeout counter clears on entry to BUSY and increments every BUSY cycle. Its width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates rather than wrapping.
- Requester inputs change after grant have no effect on the bus transaction in flight.
- **Reset (`rst_n` low, any state)**
  - State goes to IDLE and `last_grant` goes to DMEM, so imem wins the first tie.
  - All outputs go to 0, except `wb_sel_o`, which resets to 0 and is driven only in BUSY.
  - A transaction in flight is dropped with no response to the requester.

## Timing
- A request sampled high in IDLE at edge N gives `cyc`/`stb` high from N+1.
- A slave ack at edge N+k gives the requester ack during cycle N+k+1, with `cyc` low in that cycle.
- Earliest return to IDLE is N+k+2. The minimum requester round trip is 3 cycles when the slave acks in its first BUSY cycle.
- A held request is re-arbitrated in IDLE at N+k+2.
  - The requester must drop or update `req` by that edge.
  - With both requests held continuously, grants alternate imem, dmem, imem, …
- Timeout: `err` is issued in the cycle after the `TIMEOUT_CYCLES`-th BUSY cycle without a response.
- No combinational path exists from any input to any output.

## Structure
- Shared package `harv_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t`
  - `typedef enum logic {GNT_IMEM, GNT_DMEM} grant_t`
  - `localparam WB_SEL_ALL = 4'hF`
- The design is a single module with no sub-modules. The round-robin choice and the timeout counter are inline.

## Test plan
- **Single fetch:** `imem_req=1`, `addr=0x100`, slave acks in the first BUSY cycle with `0xDEADBEEF` → `wb_addr_o=0x100`, `we=0`, `sel=F` for 1 cycle; `imem_ack_o` with `rdata=0xDEADBEEF` 3 cycles after `req`.
- **Data write:** `dmem_req=1`, `we=1`, `sel=4'b0011`, `addr=0x2004`, `wdata=0x1234` → bus carries exactly those values; `dmem_ack_o` pulses once; `imem_ack_o` stays 0.
- **Contention:** both requests held for 4 transactions after reset → grant order imem, dmem, imem, dmem; no cycle with two acks.
- **Timeout:** `TIMEOUT_CYCLES=4`, slave never acks → `cyc` high exactly 4 cycles, then `dmem_err_o=1` and `rdata=0`; FSM back in IDLE.
- **Error vs ack:** `wb_err_i` and `wb_ack_i` asserted together → requester sees ack only.
- **Reset mid-BUSY:** `rst_n` pulled low while `cyc=1` → `cyc`, `stb` and all acks are 0 immediately (asynchronously); after release, a held imem request is granted first.
